// File: rtl/statistics_updater_if.sv
// rtl/statistics_updater_if.sv - hit/clear/init handshakes and statistics RAM port A bundle
// Purpose: groups every non-clock signal of statistics_updater.
// Ports (as seen by the updater, modport slave):
//   in : hit_valid, hit_addr, hit_inc, clr_valid, clr_addr, clr_all, ram_douta
//   out: hit_ready, clr_ready, init_done, ram_addra, ram_wea, ram_dina, sat_pulse
// Modport master is the environment side (match stage, register block, RAM).
interface statistics_updater_if #(
  parameter int C_MATCH_ADDR_WIDTH = 10,
  parameter int C_COUNTER_WIDTH    = 32,
  parameter int C_INC_WIDTH        = 16
);
  logic                          hit_valid;
  logic                          hit_ready;
  logic [C_MATCH_ADDR_WIDTH-1:0] hit_addr;
  logic [C_INC_WIDTH-1:0]        hit_inc;
  logic                          clr_valid;
  logic                          clr_ready;
  logic [C_MATCH_ADDR_WIDTH-1:0] clr_addr;
  logic                          clr_all;
  logic                          init_done;
  logic [C_MATCH_ADDR_WIDTH-1:0] ram_addra;
  logic                          ram_wea;
  logic [C_COUNTER_WIDTH-1:0]    ram_dina;
  logic [C_COUNTER_WIDTH-1:0]    ram_douta;
  logic                          sat_pulse;

  modport slave (
    input  hit_valid, hit_addr, hit_inc, clr_valid, clr_addr, clr_all, ram_douta,
    output hit_ready, clr_ready, init_done, ram_addra, ram_wea, ram_dina, sat_pulse
  );

  modport master (
    output hit_valid, hit_addr, hit_inc, clr_valid, clr_addr, clr_all, ram_douta,
    input  hit_ready, clr_ready, init_done, ram_addra, ram_wea, ram_dina, sat_pulse
  );
endinterface

// File: rtl/statistics_updater.sv
// rtl/statistics_updater.sv - saturating read-modify-write engine for the per-flow statistics RAM
// Purpose: zeroes the statistics RAM after reset or on clr_all, executes single-entry
//   clears and applies hit increments with saturation through RAM port A.
// Ports:
//   clk    : single clock, shared with the RAM port A
//   resetn : asynchronous active-low reset
//   bus    : statistics_updater_if.slave (hit/clear handshakes, init_done, RAM port A, sat_pulse)
module statistics_updater #(
  parameter int C_MATCH_ADDR_WIDTH = 10,
  parameter int C_COUNTER_WIDTH    = 32,
  parameter int C_INC_WIDTH        = 16
) (
  input logic                  clk,
  input logic                  resetn,
  statistics_updater_if.slave  bus
);
  localparam int AW = C_MATCH_ADDR_WIDTH;
  localparam int CW = C_COUNTER_WIDTH;
  localparam int IW = C_INC_WIDTH;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   sweep_q, sweep_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [IW-1:0]   inc_q, inc_d;

  logic            hit_take;
  logic [CW:0]     sum;

  logic            hit_ready_c, clr_ready_c, init_done_c, ram_wea_c, sat_pulse_c;
  logic [AW-1:0]   ram_addra_c;
  logic [CW-1:0]   ram_dina_c;

  // A hit may only be taken when no clear of any kind is pending.
  assign hit_take = bus.hit_valid && !bus.clr_all && !bus.clr_valid;

  // One extra bit catches the carry so the write-back can saturate instead of wrapping.
  assign sum = {1'b0, bus.ram_douta} + {{(CW + 1 - IW){1'b0}}, inc_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      addr_q  <= '0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      addr_q  <= addr_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    addr_d  = addr_q;
    inc_d   = inc_q;
    case (state_q)
      S_INIT: begin
        // Wraps back to zero on the last address, ready for the next sweep.
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.clr_all) begin
          sweep_d = '0;
          state_d = S_INIT;
        end else if (bus.clr_valid) begin
          addr_d  = bus.clr_addr;
          state_d = S_CLEAR;
        end else if (bus.hit_valid) begin
          addr_d  = bus.hit_addr;
          inc_d   = bus.hit_inc;
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (hit_take) begin
          addr_d  = bus.hit_addr;
          inc_d   = bus.hit_inc;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Outputs are held at their reset values while resetn is low so an INIT
  // state under reset never presents a write to the RAM.
  always_comb begin
    hit_ready_c = 1'b0;
    clr_ready_c = 1'b0;
    init_done_c = 1'b0;
    ram_wea_c   = 1'b0;
    ram_addra_c = '0;
    ram_dina_c  = '0;
    sat_pulse_c = 1'b0;
    if (resetn) begin
      case (state_q)
        S_INIT: begin
          ram_addra_c = sweep_q;
          ram_wea_c   = 1'b1;
        end
        S_IDLE: begin
          init_done_c = !bus.clr_all;
          clr_ready_c = !bus.clr_all;
          hit_ready_c = !bus.clr_all && !bus.clr_valid;
        end
        S_READ: begin
          init_done_c = 1'b1;
          ram_addra_c = addr_q;
        end
        S_WRITE: begin
          init_done_c = 1'b1;
          ram_addra_c = addr_q;
          ram_wea_c   = 1'b1;
          ram_dina_c  = sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
          sat_pulse_c = sum[CW];
          hit_ready_c = !bus.clr_all && !bus.clr_valid;
        end
        S_CLEAR: begin
          init_done_c = 1'b1;
          ram_addra_c = addr_q;
          ram_wea_c   = 1'b1;
        end
        default: begin
          init_done_c = 1'b0;
        end
      endcase
    end
  end

  assign bus.hit_ready = hit_ready_c;
  assign bus.clr_ready = clr_ready_c;
  assign bus.init_done = init_done_c;
  assign bus.ram_wea   = ram_wea_c;
  assign bus.ram_addra = ram_addra_c;
  assign bus.ram_dina  = ram_dina_c;
  assign bus.sat_pulse = sat_pulse_c;
endmodule
